// File: rtl/temp_meas_seq_if.sv
// temp_meas_seq_if
//   Request/result handshake bundle between the system register side
//   (master) and the temperature measurement sequencer (slave).
//
//   Signals:
//     start        master->slave  single-cycle measurement request
//     result_ack   master->slave  consumer has taken the result
//     cont_stop    master->slave  only with TEMP_MEAS_SEQ_CONT_EN: leave
//                                 continuous mode at the next ack
//     busy         slave->master  measurement in progress
//     result_valid slave->master  ptat_sum/ctat_sum/error valid
//     error        slave->master  timeout occurred (qualified by result_valid)
//     ptat_sum     slave->master  accumulated PTAT high cycles
//     ctat_sum     slave->master  accumulated CTAT high cycles
//
//   Optional feature macro: TEMP_MEAS_SEQ_CONT_EN
interface temp_meas_seq_if #(
  parameter int CW = 16
);
  logic          start;
  logic          result_ack;
  logic          busy;
  logic          result_valid;
  logic          error;
  logic [CW-1:0] ptat_sum;
  logic [CW-1:0] ctat_sum;

`ifdef TEMP_MEAS_SEQ_CONT_EN
  logic          cont_stop;

  modport master (
    output start, result_ack, cont_stop,
    input  busy, result_valid, error, ptat_sum, ctat_sum
  );

  modport slave (
    input  start, result_ack, cont_stop,
    output busy, result_valid, error, ptat_sum, ctat_sum
  );
`else
  modport master (
    output start, result_ack,
    input  busy, result_valid, error, ptat_sum, ctat_sum
  );

  modport slave (
    input  start, result_ack,
    output busy, result_valid, error, ptat_sum, ctat_sum
  );
`endif
endinterface

// File: rtl/temp_meas_seq.sv
// temp_meas_seq
//   Measurement sequencer for the PTAT/CTAT temperature-sensor digital core.
//   A request resets the sensor core, waits for its first PTAT phase, then
//   accumulates PTAT and CTAT high time over NPER complete periods and
//   returns both sums through a valid/ack handshake.
//
//   Ports:
//     clk          system clock
//     reset_n      asynchronous active-low reset
//     bus          temp_meas_seq_if.slave (start, result_ack, busy,
//                  result_valid, error, ptat_sum, ctat_sum [, cont_stop])
//     ptat_i       sensor PTAT phase active, synchronous to clk
//     ctat_i       sensor CTAT phase active, synchronous to clk
//     sensor_reset drives the sensor core reset input (high = held quiet)
//
//   Parameters: NPER (periods per measurement), CW (sum width),
//               RST_CYC (sensor reset length), TIMEOUT (idle cycles to error)
//
//   Optional feature macro: TEMP_MEAS_SEQ_CONT_EN
//     When defined, an ack in DONE restarts the measurement directly unless
//     bus.cont_stop is high at the ack.
module temp_meas_seq #(
  parameter int NPER    = 16,
  parameter int CW      = 16,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           reset_n,
  temp_meas_seq_if.slave bus,
  input  logic           ptat_i,
  input  logic           ctat_i,
  output logic           sensor_reset
);

  localparam int PW = $clog2(NPER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [PW-1:0] NPER_L     = PW'(NPER);
  localparam logic [TW-1:0] TIMEOUT_L  = TW'(TIMEOUT);
  localparam logic [RW-1:0] RST_LAST_L = RW'(RST_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SRST,
    WARM,
    MEAS,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ptat_acc_q, ptat_acc_d;
  logic [CW-1:0] ctat_acc_q, ctat_acc_d;
  logic [CW-1:0] ptat_sum_q, ptat_sum_d;
  logic [CW-1:0] ctat_sum_q, ctat_sum_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          ctat_prev_q, ctat_prev_d;
  logic          sensor_reset_q, sensor_reset_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;

  logic          launch;
  logic          ctat_fall;
  logic [TW-1:0] to_next;

  // Counters saturate at all-ones so a stuck-high phase never wraps to a
  // small value.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Next-state and datapath computation. Outputs are registered from the
  // next state so busy/sensor_reset change on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    ptat_acc_d  = ptat_acc_q;
    ctat_acc_d  = ctat_acc_q;
    ptat_sum_d  = ptat_sum_q;
    ctat_sum_d  = ctat_sum_q;
    per_cnt_d   = per_cnt_q;
    to_cnt_d    = to_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    valid_d     = valid_q;
    error_d     = error_q;
    ctat_prev_d = ctat_i;
    launch      = 1'b0;

    // The timeout counter restarts on any sensor activity.
    to_next   = (ptat_i | ctat_i) ? '0 : to_cnt_q + TW'(1);
    ctat_fall = ctat_prev_q & ~ctat_i;

    case (state_q)
      IDLE: begin
        launch = bus.start;
      end

      SRST: begin
        if (rst_cnt_q == RST_LAST_L) begin
          state_d = WARM;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      WARM: begin
        to_cnt_d = to_next;
        if (ptat_i) begin
          state_d    = MEAS;
          ptat_acc_d = sat_inc(ptat_acc_q);
        end else if (to_next == TIMEOUT_L) begin
          state_d = DONE;
          error_d = 1'b1;
        end
      end

      MEAS: begin
        to_cnt_d = to_next;
        if (ptat_i) ptat_acc_d = sat_inc(ptat_acc_q);
        if (ctat_i) ctat_acc_d = sat_inc(ctat_acc_q);
        if (ctat_fall) per_cnt_d = per_cnt_q + PW'(1);
        if (to_next == TIMEOUT_L) begin
          state_d = DONE;
          error_d = 1'b1;
        end else if (ctat_fall && (per_cnt_d == NPER_L)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.result_ack) begin
          valid_d = 1'b0;
`ifdef TEMP_MEAS_SEQ_CONT_EN
          if (bus.cont_stop) state_d = IDLE;
          else               launch  = 1'b1;
`else
          state_d = IDLE;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    // A new run, whether requested or a continuous restart, starts clean.
    if (launch) begin
      state_d    = SRST;
      ptat_acc_d = '0;
      ctat_acc_d = '0;
      per_cnt_d  = '0;
      to_cnt_d   = '0;
      rst_cnt_d  = '0;
      error_d    = 1'b0;
    end

    // Sums are captured from this cycle's accumulator values on DONE entry.
    if ((state_d == DONE) && (state_q != DONE)) begin
      ptat_sum_d = ptat_acc_d;
      ctat_sum_d = ctat_acc_d;
      valid_d    = 1'b1;
    end

    busy_d         = (state_d == SRST) || (state_d == WARM) || (state_d == MEAS);
    sensor_reset_d = !((state_d == WARM) || (state_d == MEAS));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ptat_acc_q     <= '0;
      ctat_acc_q     <= '0;
      ptat_sum_q     <= '0;
      ctat_sum_q     <= '0;
      per_cnt_q      <= '0;
      to_cnt_q       <= '0;
      rst_cnt_q      <= '0;
      ctat_prev_q    <= 1'b0;
      sensor_reset_q <= 1'b1;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptat_acc_q     <= ptat_acc_d;
      ctat_acc_q     <= ctat_acc_d;
      ptat_sum_q     <= ptat_sum_d;
      ctat_sum_q     <= ctat_sum_d;
      per_cnt_q      <= per_cnt_d;
      to_cnt_q       <= to_cnt_d;
      rst_cnt_q      <= rst_cnt_d;
      ctat_prev_q    <= ctat_prev_d;
      sensor_reset_q <= sensor_reset_d;
      busy_q         <= busy_d;
      valid_q        <= valid_d;
      error_q        <= error_d;
    end
  end

  assign sensor_reset     = sensor_reset_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.error        = error_q;
  assign bus.ptat_sum     = ptat_sum_q;
  assign bus.ctat_sum     = ctat_sum_q;

endmodule

// File: tb/tb_temp_meas_seq.sv
// tb_temp_meas_seq
//   Scoreboard bench for temp_meas_seq built with NPER=2, CW=8, RST_CYC=4,
//   TIMEOUT=64. A simple sensor model produces idle/PTAT/idle/CTAT phases
//   after its reset is released. Each measurement request pushes its
//   expected sums into a queue; a monitor pops and compares on every rising
//   result_valid.
module tb_temp_meas_seq;

  localparam int NPER    = 2;
  localparam int CW      = 8;
  localparam int RST_CYC = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    int p;
    int c;
    int e;
  } exp_t;

  logic clk;
  logic reset_n;
  logic ptat_i;
  logic ctat_i;
  logic sensor_reset;

  temp_meas_seq_if #(.CW(CW)) bus ();

  temp_meas_seq #(
    .NPER   (NPER),
    .CW     (CW),
    .RST_CYC(RST_CYC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .ptat_i      (ptat_i),
    .ctat_i      (ctat_i),
    .sensor_reset(sensor_reset)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int   p_len = 100;
  int   c_len = 60;
  int   gap   = 3;
  bit   stuck = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor model: idle gap, PTAT phase, idle gap, CTAT phase, repeating,
  // restarting from the first gap whenever its reset is high.
  initial begin
    int pos;
    int period;
    pos    = 0;
    ptat_i = 1'b0;
    ctat_i = 1'b0;
    forever begin
      @(negedge clk);
      if (sensor_reset || stuck) begin
        pos    = 0;
        ptat_i = 1'b0;
        ctat_i = 1'b0;
      end else begin
        period = 2 * gap + p_len + c_len;
        ptat_i = (pos >= gap) && (pos < gap + p_len);
        ctat_i = (pos >= 2 * gap + p_len) && (pos < period);
        pos    = (pos + 1 == period) ? 0 : pos + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Issues a start pulse; returns at the negedge after the sampling edge.
  task automatic applyStimulus(input bit expect_result, input int p, input int c, input int e);
    exp_t x;
    if (expect_result) begin
      x.p = p;
      x.c = c;
      x.e = e;
      exp_q.push_back(x);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for result_valid; returns cycles waited.
  task automatic waitResult(input string name, input int budget, output int n);
    n = 0;
    while (!bus.result_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.result_valid) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  // Acks in the current cycle and checks the handshake drops next cycle.
  task automatic ackResult(input string name, input int busy_exp);
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    checkOutput({name, "_valid_after_ack"}, int'(bus.result_valid), 0);
    checkOutput({name, "_busy_after_ack"}, int'(bus.busy), busy_exp);
  endtask

  // Scoreboard monitor.
  initial begin
    logic prev_valid;
    exp_t x;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          x = exp_q.pop_front();
          checkOutput("ptat_sum", int'(bus.ptat_sum), x.p);
          checkOutput("ctat_sum", int'(bus.ctat_sum), x.c);
          checkOutput("error", int'(bus.error), x.e);
          checkOutput("done_sensor_reset", int'(sensor_reset), 1);
          checkOutput("done_busy", int'(bus.busy), 0);
        end
      end
      prev_valid = bus.result_valid;
    end
  end

  initial begin
    int n;
    int stable;

    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.result_ack = 1'b0;
`ifdef TEMP_MEAS_SEQ_CONT_EN
    bus.cont_stop  = 1'b1;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_sensor_reset", int'(sensor_reset), 1);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_valid", int'(bus.result_valid), 0);
    checkOutput("rst_error", int'(bus.error), 0);
    checkOutput("rst_ptat_sum", int'(bus.ptat_sum), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run with start latency checks.
    $display("[TB] basic run");
    applyStimulus(1'b1, 200, 120, 0);
    checkOutput("start_busy", int'(bus.busy), 1);
    for (int i = 0; i < RST_CYC; i++) begin
      checkOutput("srst_sensor_reset_high", int'(sensor_reset), 1);
      @(negedge clk);
    end
    checkOutput("warm_sensor_reset_low", int'(sensor_reset), 0);
    waitResult("basic", 1000, n);

    // Hold the result unacknowledged; a start in DONE must be ignored.
    $display("[TB] handshake hold");
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.start = (i == 20);
      if (bus.result_valid && bus.ptat_sum == 8'd200 && bus.ctat_sum == 8'd120 && !bus.busy)
        stable++;
    end
    bus.start = 1'b0;
    checkOutput("hold_stable_cycles", stable, 50);
    ackResult("basic", 0);
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", int'(bus.busy), 0);

    // Saturation; ack in the first DONE cycle.
    $display("[TB] saturation");
    p_len = 300;
    applyStimulus(1'b1, 255, 120, 0);
    waitResult("sat", 2000, n);
    ackResult("sat", 0);
    p_len = 100;

    // Reset during MEAS discards the partial run.
    $display("[TB] reset mid-measurement");
    applyStimulus(1'b0, 0, 0, 0);
    repeat (250) @(negedge clk);
    checkOutput("mid_busy_before_reset", int'(bus.busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_busy", int'(bus.busy), 0);
    checkOutput("mid_rst_valid", int'(bus.result_valid), 0);
    checkOutput("mid_rst_ptat_sum", int'(bus.ptat_sum), 0);
    checkOutput("mid_rst_ctat_sum", int'(bus.ctat_sum), 0);
    checkOutput("mid_rst_sensor_reset", int'(sensor_reset), 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 200, 120, 0);
    waitResult("after_reset", 1000, n);
    ackResult("after_reset", 0);

    // Stuck sensor: timeout after TIMEOUT idle WARM cycles.
    $display("[TB] stuck sensor");
    stuck = 1'b1;
    applyStimulus(1'b1, 0, 0, 1);
    waitResult("stuck", 200, n);
    checkOutput("stuck_latency", n, RST_CYC + TIMEOUT);
    ackResult("stuck", 0);
    stuck = 1'b0;

`ifdef TEMP_MEAS_SEQ_CONT_EN
    // Continuous mode: four results from a single start.
    $display("[TB] continuous mode");
    bus.cont_stop = 1'b0;
    for (int r = 0; r < 4; r++) begin
      exp_t x;
      x.p = 200;
      x.c = 120;
      x.e = 0;
      exp_q.push_back(x);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      waitResult("cont", 1000, n);
      if (r == 3) bus.cont_stop = 1'b1;
      ackResult("cont", (r < 3) ? 1 : 0);
    end
    repeat (5) @(negedge clk);
    checkOutput("cont_stop_busy", int'(bus.busy), 0);
    checkOutput("cont_stop_valid", int'(bus.result_valid), 0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
